// File: rtl/window_serializer.sv
`default_nettype none
// ============================================================================
// Module   : window_serializer
// Brief    : Converts an N-word parallel window into a stream of B-bit words
//            with valid/ready handshakes on both sides. A shadow stage lets
//            the next window be captured while the current one is shifting,
//            so windows can be emitted back to back without gaps.
// Macro    : WINDOW_SERIALIZER_MSB_FIRST_EN
//            Undefined : emit din[0] first, din[N-1] last.
//            Defined   : emit din[N-1] first, din[0] last.
// Revision : 1.0 - initial release
// ============================================================================
module window_serializer #(
  parameter int N = 11,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [B-1:0] din [N-1:0],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [B-1:0] dout,
  output logic         out_last
);

  localparam int            IW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_BUSY_FULL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          full_q, full_d;
  logic [B-1:0]  shift_q  [N-1:0];
  logic [B-1:0]  shift_d  [N-1:0];
  logic [B-1:0]  shadow_q [N-1:0];
  logic [B-1:0]  shadow_d [N-1:0];

  logic          accept;
  logic          beat;
  logic          last_beat;
  logic [IW-1:0] sel_idx;

  // Handshake outputs and word selection, all decoded from registered state.
  // in_ready depends on the shadow flag only, so no input feeds back into it.
  always_comb begin
    in_ready  = ~full_q;
    out_valid = (state_q != ST_IDLE);
    out_last  = out_valid && (idx_q == C_LAST_IDX);
`ifdef WINDOW_SERIALIZER_MSB_FIRST_EN
    sel_idx   = C_LAST_IDX - idx_q;
`else
    sel_idx   = idx_q;
`endif
    dout      = out_valid ? shift_q[sel_idx] : '0;
    accept    = in_valid && in_ready;
    beat      = out_valid && out_ready;
    last_beat = beat && out_last;
  end

  // Next-state logic: load, advance, refill from shadow or from the input.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    full_d   = full_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = din;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_beat) begin
          // Final word leaves this cycle; a simultaneous accept goes straight
          // into the shift stage so out_valid never drops between windows.
          idx_d = '0;
          if (accept) begin
            shift_d = din;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (beat) begin
            idx_d = idx_q + 1'b1;
          end
          if (accept) begin
            shadow_d = din;
            full_d   = 1'b1;
            state_d  = ST_BUSY_FULL;
          end
        end
      end
      ST_BUSY_FULL: begin
        if (last_beat) begin
          shift_d = shadow_q;
          idx_d   = '0;
          full_d  = 1'b0;
          state_d = ST_BUSY;
        end else if (beat) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        full_d  = 1'b0;
      end
    endcase
  end

  // State and storage registers; reset wins over any accept or beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shift_q[i]  <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      full_q   <= full_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_serializer
// Brief    : Self-checking bench for window_serializer. A queue of expected
//            words (one entry per word, with its last flag) predicts the
//            output stream, out_valid and in_ready.
// Macro    : WINDOW_SERIALIZER_MSB_FIRST_EN (must match the DUT build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_serializer;

  localparam int N = 11;
  localparam int B = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] din  [N-1:0];
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] dout;
  logic         out_last;

  logic [B-1:0] stim [N-1:0];
  logic [B-1:0] w    [N-1:0];

  int checks = 0;
  int errors = 0;

  // Reference model: words still owed to the output, in emission order.
  logic [B-1:0] mq [$];
  logic         lq [$];
  logic         exp_valid;
  logic         exp_ready;
  logic         exp_last;
  logic [B-1:0] exp_dout;

  window_serializer #(.N(N), .B(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  // Position in the window of the k-th emitted word.
  function automatic int ord(input int k);
`ifdef WINDOW_SERIALIZER_MSB_FIRST_EN
    return N - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) stim[i] = B'($urandom);
  endtask

  // Apply inputs after the falling edge and compute the expected outputs.
  // A window is outstanding beyond the current one exactly when more than
  // N words are owed, which is when the block must refuse new input.
  task automatic drive(input logic rs, input logic v, input logic r);
    @(negedge clk);
    rst       = rs;
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < N; i++) din[i] = stim[i];
    #1;
    exp_valid = (mq.size() > 0);
    exp_ready = (mq.size() <= N);
    exp_dout  = exp_valid ? mq[0] : '0;
    exp_last  = exp_valid ? lq[0] : 1'b0;
  endtask

  // Take the rising edge and update the model with what transferred.
  task automatic advance();
    logic acc;
    logic bt;
    acc = in_valid && exp_ready;
    bt  = out_ready && exp_valid;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      lq.delete();
    end else begin
      if (bt) begin
        void'(mq.pop_front());
        void'(lq.pop_front());
      end
      if (acc) begin
        for (int k = 0; k < N; k++) begin
          mq.push_back(din[ord(k)]);
          lq.push_back(k == N - 1);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * N && mq.size() > 0; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      advance();
    end
  endtask

  task automatic test_reset();
    fill_random();
    drive(1'b1, 1'b1, 1'b1);
    advance();
    drive(1'b1, 1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state valid=%b dout=%0d last=%b ready=%b required 0,0,0,1",
               out_valid, dout, out_last, in_ready);
    end
    advance();
    drain();
  endtask

  task automatic test_single_window();
    logic [B-1:0] expw;
    for (int i = 0; i < N; i++) stim[i] = B'(3 + 13 * i);
    drive(1'b0, 1'b1, 1'b1);
    advance();
    for (int k = 0; k < N; k++) begin
      fill_random();
`ifdef WINDOW_SERIALIZER_MSB_FIRST_EN
      expw = B'(133 - 13 * k);
`else
      expw = B'(3 + 13 * k);
`endif
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || dout !== expw || out_last !== (k == N - 1)) begin
        errors++;
        $display("FAIL single beat=%0d valid=%b dout=%0d last=%b required 1,%0d,%b",
                 k, out_valid, dout, out_last, expw, (k == N - 1));
      end
      advance();
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end valid=%b required 0", out_valid);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic         b_taken;
    logic [B-1:0] expw;
    for (int i = 0; i < N; i++) stim[i] = B'(i);
    drive(1'b0, 1'b1, 1'b1);
    advance();
    b_taken = 1'b0;
    for (int i = 0; i < N; i++) stim[i] = B'(100 + i);
    for (int j = 0; j < 2 * N; j++) begin
      expw = (j < N) ? B'(ord(j)) : B'(100 + ord(j - N));
      drive(1'b0, !b_taken, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || dout !== expw || out_last !== exp_last ||
          in_ready !== (j == 0 || j >= N)) begin
        errors++;
        $display("FAIL b2b beat=%0d valid=%b dout=%0d last=%b ready=%b required 1,%0d,%b,%b",
                 j, out_valid, dout, out_last, in_ready, expw, exp_last, (j == 0 || j >= N));
      end
      if (!b_taken && exp_ready) b_taken = 1'b1;
      advance();
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end valid=%b required 0", out_valid);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int   j;
    int   hold;
    int   cyc;
    logic r;
    fill_random();
    for (int i = 0; i < N; i++) w[i] = stim[i];
    drive(1'b0, 1'b1, 1'b1);
    advance();
    j = 0; hold = 0; cyc = 0;
    while (j < N && cyc < 30) begin
      r = !(j == 4 && hold < 3);
      fill_random();
      drive(1'b0, 1'b0, r);
      checks++;
      if (out_valid !== 1'b1 || dout !== w[ord(j)] || out_last !== (j == N - 1)) begin
        errors++;
        $display("FAIL backpressure word=%0d valid=%b dout=%0d last=%b required 1,%0d,%b",
                 j, out_valid, dout, out_last, w[ord(j)], (j == N - 1));
      end
      advance();
      if (r) j++; else hold++;
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (cyc != N + 3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_total cycles=%0d valid=%b required %0d,0", cyc, out_valid, N + 3);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    fill_random();
    drive(1'b0, 1'b1, 1'b1);
    advance();
    for (int j = 0; j < 6; j++) begin
      drive(1'b0, 1'b0, 1'b1);
      advance();
    end
    fill_random();
    drive(1'b1, 1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || dout !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid valid=%b dout=%0d ready=%b required 0,0,1", out_valid, dout, in_ready);
    end
    advance();
    fill_random();
    for (int i = 0; i < N; i++) w[i] = stim[i];
    drive(1'b0, 1'b1, 1'b1);
    advance();
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || dout !== w[ord(0)]) begin
      errors++;
      $display("FAIL reset_mid_restart valid=%b dout=%0d required 1,%0d", out_valid, dout, w[ord(0)]);
    end
    advance();
    drain();
  endtask

  task automatic test_throughput();
    int beats;
    fill_random();
    drive(1'b0, 1'b1, 1'b1);
    advance();
    beats = 0;
    for (int c = 0; c < 3 * N; c++) begin
      fill_random();
      drive(1'b0, 1'b1, 1'b1);
      checks++;
      if (out_valid !== exp_valid || in_ready !== exp_ready ||
          (exp_valid && (dout !== exp_dout || out_last !== exp_last))) begin
        errors++;
        $display("FAIL throughput cyc=%0d valid=%b/%b ready=%b/%b dout=%0d/%0d last=%b/%b",
                 c, out_valid, exp_valid, in_ready, exp_ready, dout, exp_dout, out_last, exp_last);
      end
      if (out_valid === 1'b1) beats++;
      advance();
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (beats != 3 * N) begin
      errors++;
      $display("FAIL throughput_beats got=%0d required %0d", beats, 3 * N);
    end
    advance();
    drain();
  endtask

  task automatic test_random();
    logic rs;
    logic v;
    logic r;
    for (int c = 0; c < 600; c++) begin
      rs = ($urandom % 150) == 0;
      v  = ($urandom % 4) != 0;
      r  = ($urandom % 3) != 0;
      fill_random();
      drive(rs, v, r);
      checks++;
      if (out_valid !== exp_valid || in_ready !== exp_ready ||
          (exp_valid && (dout !== exp_dout || out_last !== exp_last)) ||
          (!exp_valid && out_last !== 1'b0)) begin
        errors++;
        $display("FAIL random cyc=%0d valid=%b/%b ready=%b/%b dout=%0d/%0d last=%b/%b",
                 c, out_valid, exp_valid, in_ready, exp_ready, dout, exp_dout, out_last, exp_last);
      end
      advance();
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      stim[i] = '0;
      din[i]  = '0;
      w[i]    = '0;
    end
    test_reset();
    test_single_window();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
